// File: rtl/jtkcpu_aluctl_pkg.sv
// Shared constants for the ALU sequencer: request kinds, the opcodes the
// sequencer cares about, and its state encoding.
package jtkcpu_aluctl_pkg;

    localparam logic [1:0] KIND_SINGLE = 2'd0;
    localparam logic [1:0] KIND_SHIFT  = 2'd1;
    localparam logic [1:0] KIND_DIV    = 2'd2;
    localparam logic [1:0] KIND_LMUL   = 2'd3;

    localparam logic [7:0] OP_ADDA_IMM = 8'h8B;
    localparam logic [7:0] OP_ASLD_IMM = 8'h58;
    localparam logic [7:0] OP_DIVXB    = 8'h3D;
    localparam logic [7:0] OP_LMUL     = 8'h3E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_STEP,
        ST_DIVW,
        ST_DONE
    } state_e;

    function automatic logic [7:0] satCount(input logic [7:0] raw, input int maxShift);
        satCount = (int'(raw) > maxShift) ? 8'(maxShift) : raw;
    endfunction

endpackage

// File: rtl/jtkcpu_aluctl.sv
// Drives the ALU command interface for one decoded request, runs the
// multi-cycle shift/divide/long-multiply sequences, and emits one writeback beat.
module jtkcpu_aluctl
    import jtkcpu_aluctl_pkg::*;
#(
    parameter int SETTLE   = 1,
    parameter int MAXSHIFT = 255
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        req,
    output logic        rdy,
    input  logic [1:0]  kind,
    input  logic [7:0]  op,
    input  logic [15:0] a0,
    input  logic [15:0] a1,
    input  logic [7:0]  cc_i,
    output logic [7:0]  alu_op,
    output logic [15:0] alu_opnd0,
    output logic [15:0] alu_opnd1,
    output logic [7:0]  alu_cc,
    output logic        alu_div_en,
    input  logic        alu_busy,
    input  logic [15:0] alu_rslt,
    input  logic [15:0] alu_rslt_hi,
    input  logic [7:0]  alu_cc_out,
    output logic        wr_we,
    output logic        wr_hi_we,
    output logic [15:0] wr_data,
    output logic [15:0] wr_hi,
    output logic [7:0]  wr_cc
);

    state_e      state_q;
    logic [1:0]  kind_q;
    logic [7:0]  cnt_q;
    logic [7:0]  settle_q;
    logic        rdy_q;
    logic [7:0]  alu_op_q;
    logic [15:0] alu_opnd0_q;
    logic [15:0] alu_opnd1_q;
    logic [7:0]  alu_cc_q;
    logic        alu_div_en_q;
    logic        wr_we_q;
    logic        wr_hi_we_q;
    logic [15:0] wr_data_q;
    logic [15:0] wr_hi_q;
    logic [7:0]  wr_cc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            kind_q       <= KIND_SINGLE;
            cnt_q        <= '0;
            settle_q     <= '0;
            rdy_q        <= 1'b1;
            alu_op_q     <= '0;
            alu_opnd0_q  <= '0;
            alu_opnd1_q  <= '0;
            alu_cc_q     <= '0;
            alu_div_en_q <= 1'b0;
            wr_we_q      <= 1'b0;
            wr_hi_we_q   <= 1'b0;
            wr_data_q    <= '0;
            wr_hi_q      <= '0;
            wr_cc_q      <= '0;
        end else if (cen) begin
            case (state_q)
                ST_IDLE: begin
                    if (req && rdy_q) begin
                        alu_op_q    <= op;
                        alu_opnd0_q <= a0;
                        alu_opnd1_q <= a1;
                        alu_cc_q    <= cc_i;
                        kind_q      <= kind;
                        cnt_q       <= satCount(a1[7:0], MAXSHIFT);
                        settle_q    <= '0;
                        rdy_q       <= 1'b0;
                        state_q     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q != 8'(SETTLE - 1)) begin
                        settle_q <= settle_q + 8'd1;
                    end else begin
                        case (kind_q)
                            KIND_SHIFT: begin
                                // A zero-length shift never steps the ALU: pass the operand through.
                                if (cnt_q == 8'd0) begin
                                    wr_data_q  <= alu_opnd0_q;
                                    wr_cc_q    <= alu_cc_q;
                                    wr_hi_we_q <= 1'b0;
                                    wr_we_q    <= 1'b1;
                                    state_q    <= ST_DONE;
                                end else begin
                                    state_q <= ST_STEP;
                                end
                            end
                            KIND_DIV: begin
                                alu_div_en_q <= 1'b1;
                                state_q      <= ST_DIVW;
                            end
                            default: begin
                                wr_data_q  <= alu_rslt;
                                wr_hi_q    <= alu_rslt_hi;
                                wr_cc_q    <= alu_cc_out;
                                wr_hi_we_q <= (kind_q == KIND_LMUL);
                                wr_we_q    <= 1'b1;
                                state_q    <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_STEP: begin
                    alu_opnd0_q <= alu_rslt;
                    alu_cc_q    <= alu_cc_out;
                    cnt_q       <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        wr_data_q  <= alu_rslt;
                        wr_cc_q    <= alu_cc_out;
                        wr_hi_we_q <= 1'b0;
                        wr_we_q    <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DIVW: begin
                    // Busy is not yet valid on the start-pulse cycle.
                    if (alu_div_en_q) begin
                        alu_div_en_q <= 1'b0;
                    end else if (!alu_busy) begin
                        wr_data_q  <= alu_rslt;
                        wr_hi_q    <= alu_rslt_hi;
                        wr_cc_q    <= alu_cc_out;
                        wr_hi_we_q <= 1'b1;
                        wr_we_q    <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    wr_we_q    <= 1'b0;
                    wr_hi_we_q <= 1'b0;
                    rdy_q      <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdy        = rdy_q;
    assign alu_op     = alu_op_q;
    assign alu_opnd0  = alu_opnd0_q;
    assign alu_opnd1  = alu_opnd1_q;
    assign alu_cc     = alu_cc_q;
    assign alu_div_en = alu_div_en_q;
    assign wr_we      = wr_we_q;
    assign wr_hi_we   = wr_hi_we_q;
    assign wr_data    = wr_data_q;
    assign wr_hi      = wr_hi_q;
    assign wr_cc      = wr_cc_q;

endmodule

// File: tb/tb_jtkcpu_aluctl.sv
// Self-checking bench for jtkcpu_aluctl with a small behavioural ALU
// (8-bit add, 16-bit shift-left, iterative divide, long multiply).
module tb_jtkcpu_aluctl;
    import jtkcpu_aluctl_pkg::*;

    logic        rst, clk, cen, req, rdy;
    logic [1:0]  kind;
    logic [7:0]  op, cc_i, alu_op, alu_cc, alu_cc_out, wr_cc;
    logic [15:0] a0, a1, alu_opnd0, alu_opnd1, alu_rslt, alu_rslt_hi, wr_data, wr_hi;
    logic        alu_div_en, alu_busy, wr_we, wr_hi_we;

    int nCompared   = 0;
    int nMismatched = 0;
    int wrCount     = 0;
    int divPulses   = 0;

    jtkcpu_aluctl #(.SETTLE(1), .MAXSHIFT(255)) dut (
        .rst(rst), .clk(clk), .cen(cen), .req(req), .rdy(rdy),
        .kind(kind), .op(op), .a0(a0), .a1(a1), .cc_i(cc_i),
        .alu_op(alu_op), .alu_opnd0(alu_opnd0), .alu_opnd1(alu_opnd1), .alu_cc(alu_cc),
        .alu_div_en(alu_div_en), .alu_busy(alu_busy), .alu_rslt(alu_rslt),
        .alu_rslt_hi(alu_rslt_hi), .alu_cc_out(alu_cc_out),
        .wr_we(wr_we), .wr_hi_we(wr_hi_we), .wr_data(wr_data), .wr_hi(wr_hi), .wr_cc(wr_cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: combinational results, divider busy for four cen cycles after start.
    logic [8:0]  sum9;
    logic [15:0] shl;
    logic [31:0] prod;
    logic [15:0] quo, rem;
    logic [2:0]  busyCnt;

    always_comb begin
        sum9        = {1'b0, alu_opnd0[7:0]} + {1'b0, alu_opnd1[7:0]};
        shl         = {alu_opnd0[14:0], 1'b0};
        prod        = alu_opnd0 * alu_opnd1;
        quo         = (alu_opnd1[7:0] == 8'd0) ? 16'hFFFF : alu_opnd0 / {8'd0, alu_opnd1[7:0]};
        rem         = (alu_opnd1[7:0] == 8'd0) ? alu_opnd0 : alu_opnd0 % {8'd0, alu_opnd1[7:0]};
        alu_rslt    = '0;
        alu_rslt_hi = '0;
        alu_cc_out  = alu_cc;
        case (alu_op)
            OP_ADDA_IMM: begin
                alu_rslt   = {alu_opnd0[15:8], sum9[7:0]};
                alu_cc_out = {alu_cc[7:4], sum9[7], sum9[7:0] == 8'd0,
                              (alu_opnd0[7] == alu_opnd1[7]) && (sum9[7] != alu_opnd0[7]), sum9[8]};
            end
            OP_ASLD_IMM: begin
                alu_rslt   = shl;
                alu_cc_out = {alu_cc[7:4], shl[15], shl == 16'd0, shl[15] ^ alu_opnd0[15], alu_opnd0[15]};
            end
            OP_DIVXB: begin
                alu_rslt    = quo;
                alu_rslt_hi = rem;
                alu_cc_out  = {alu_cc[7:3], quo == 16'd0, alu_cc[1:0]};
            end
            OP_LMUL: begin
                alu_rslt    = prod[15:0];
                alu_rslt_hi = prod[31:16];
                alu_cc_out  = {alu_cc[7:3], prod == 32'd0, alu_cc[1:0]};
            end
            default: ;
        endcase
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_busy <= 1'b0;
            busyCnt  <= '0;
        end else if (cen) begin
            if (alu_div_en) begin
                alu_busy <= 1'b1;
                busyCnt  <= 3'd3;
            end else if (alu_busy) begin
                if (busyCnt == 3'd0) alu_busy <= 1'b0;
                else busyCnt <= busyCnt - 3'd1;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && cen && wr_we) wrCount++;
        if (!rst && cen && alu_div_en) divPulses++;
    end

    typedef struct {
        logic [1:0]  kind;
        logic [7:0]  op;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [7:0]  cc;
        logic        cenGap;
        logic [15:0] expData;
        logic [15:0] expHi;
        logic        expHiWe;
        logic [7:0]  expCc;
        int          expLat;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int idx);
        vec_t v;
        int   lat;
        logic done;
        v = vecs[idx];
        @(negedge clk);
        cen  = 1'b1;
        kind = v.kind; op = v.op; a0 = v.a0; a1 = v.a1; cc_i = v.cc;
        req  = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        checkOutput($sformatf("v%0d rdy after accept", idx), 32'(rdy), 32'd0);
        checkOutput($sformatf("v%0d alu_op", idx), 32'(alu_op), 32'(v.op));
        lat  = 0;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            cen = v.cenGap ? 1'(i % 2) : 1'b1;
            @(posedge clk);
            if (cen) lat++;
            #1;
            if (wr_we) done = 1'b1;
        end
        checkOutput($sformatf("v%0d completed", idx), 32'(done), 32'd1);
        checkOutput($sformatf("v%0d latency", idx), 32'(lat), 32'(v.expLat));
        checkOutput($sformatf("v%0d wr_data", idx), 32'(wr_data), 32'(v.expData));
        checkOutput($sformatf("v%0d wr_cc", idx), 32'(wr_cc), 32'(v.expCc));
        checkOutput($sformatf("v%0d wr_hi_we", idx), 32'(wr_hi_we), 32'(v.expHiWe));
        if (v.expHiWe) checkOutput($sformatf("v%0d wr_hi", idx), 32'(wr_hi), 32'(v.expHi));
        @(negedge clk);
        cen = 1'b1;
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d rdy back", idx), 32'(rdy), 32'd1);
        checkOutput($sformatf("v%0d wr_we one beat", idx), 32'(wr_we), 32'd0);
    endtask

    initial begin
        int   wrBefore, divBefore;
        logic done;

        vecs[0] = '{KIND_SINGLE, OP_ADDA_IMM, 16'h007F, 16'h0001, 8'h00, 1'b0, 16'h0080, 16'h0000, 1'b0, 8'h0A, 1};
        vecs[1] = '{KIND_SHIFT,  OP_ASLD_IMM, 16'h1234, 16'h0003, 8'h00, 1'b0, 16'h91A0, 16'h0000, 1'b0, 8'h0A, 4};
        vecs[2] = '{KIND_SHIFT,  OP_ASLD_IMM, 16'hBEEF, 16'h0000, 8'h05, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 8'h05, 1};
        vecs[3] = '{KIND_DIV,    OP_DIVXB,    16'h0064, 16'h0007, 8'h00, 1'b0, 16'h000E, 16'h0002, 1'b1, 8'h00, 7};
        vecs[4] = '{KIND_LMUL,   OP_LMUL,     16'h1234, 16'h5678, 8'h00, 1'b0, 16'h0060, 16'h0626, 1'b1, 8'h00, 1};
        vecs[5] = '{KIND_SINGLE, OP_ADDA_IMM, 16'h00FF, 16'h0001, 8'hF0, 1'b1, 16'h0000, 16'h0000, 1'b0, 8'hF5, 1};
        vecs[6] = '{KIND_SHIFT,  OP_ASLD_IMM, 16'h0001, 16'hABFF, 8'h00, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h04, 256};
        vecs[7] = '{KIND_SHIFT,  OP_ASLD_IMM, 16'h4001, 16'h0002, 8'h00, 1'b1, 16'h0004, 16'h0000, 1'b0, 8'h03, 3};
        vecs[8] = '{KIND_DIV,    OP_DIVXB,    16'hFFFF, 16'h0010, 8'h80, 1'b1, 16'h0FFF, 16'h000F, 1'b1, 8'h80, 7};

        rst = 1'b1; cen = 1'b1; req = 1'b0;
        kind = '0; op = '0; a0 = '0; a1 = '0; cc_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset rdy", 32'(rdy), 32'd1);
        checkOutput("reset outputs", {alu_op, alu_cc, 7'd0, alu_div_en, wr_we, wr_hi_we, wr_cc[5:0]}, 32'd0);
        checkOutput("reset data", {wr_data, wr_hi}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(i);
            if (i == 2) checkOutput("zero shift opnd0 untouched", 32'(alu_opnd0), 32'h0000BEEF);
        end

        // Reset partway through a shift by 10 abandons it without a writeback.
        wrBefore = wrCount;
        @(negedge clk);
        kind = KIND_SHIFT; op = OP_ASLD_IMM; a0 = 16'h0001; a1 = 16'h000A; cc_i = 8'h00;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("four steps opnd0", 32'(alu_opnd0), 32'h00000010);
        rst = 1'b1;
        #1;
        checkOutput("midop reset rdy", 32'(rdy), 32'd1);
        checkOutput("midop reset regs", {alu_op, alu_cc, 7'd0, alu_div_en, wr_we, wr_hi_we, wr_cc[5:0]}, 32'd0);
        checkOutput("midop reset opnds", {alu_opnd0, alu_opnd1}, 32'd0);
        checkOutput("midop reset wr", {wr_data, wr_hi}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("no wr_we after reset", 32'(wrCount), 32'(wrBefore));

        // Holding req through a divide must not queue a second operation.
        wrBefore  = wrCount;
        divBefore = divPulses;
        @(negedge clk);
        kind = KIND_DIV; op = OP_DIVXB; a0 = 16'h0064; a1 = 16'h0007; cc_i = 8'h00;
        req = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            if (wr_we) done = 1'b1;
        end
        req = 1'b0;
        checkOutput("held req div completed", 32'(done), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("held req one wr_we", 32'(wrCount - wrBefore), 32'd1);
        checkOutput("held req one div pulse", 32'(divPulses - divBefore), 32'd1);
        checkOutput("held req quotient", 32'(wr_data), 32'h0000000E);
        checkOutput("held req rdy", 32'(rdy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/jtkcpu_aluctl.md
Name: jtkcpu_aluctl

Overview:
- Initiator-side sequencer that drives the ALU's operand/command interface and collects its results for writeback.
- Accepts one decoded ALU request from the microcode sequencer and presents op/operands/CC to the ALU.
- Runs the multi-cycle ops itself: iterative D shifts by N, DIVXB start/busy wait, LMUL 32-bit capture.
- Returns a single writeback beat with result, high word and CC.

Parameters:
- SETTLE, 1, cen-qualified cycles between presenting alu_op and sampling ALU outputs (covers the ALU's registered width/flag-enable decode).
- MAXSHIFT, 255, largest honoured shift count; larger counts saturate to MAXSHIFT.

Ports:
- rst  in  1  asynchronous reset, active high
- clk  in  1  single clock
- cen  in  1  clock enable; every state change, counter and capture is cen-qualified
- req  in  1  request strobe; sampled only when rdy=1
- rdy  out  1  high in IDLE only
- kind  in  2  0=single, 1=shift-N, 2=div, 3=lmul
- op  in  8  ALU opcode (shared opcode constants)
- a0  in  16  register operand
- a1  in  16  memory/immediate operand; shift count in a1[7:0] for kind 1
- cc_i  in  8  current CC
- alu_op  out  8  registered opcode to ALU
- alu_opnd0  out  16  to ALU opnd0
- alu_opnd1  out  16  to ALU opnd1
- alu_cc  out  8  to ALU cc_in
- alu_div_en  out  1  one-cen start pulse to ALU divider
- alu_busy  in  1  ALU busy
- alu_rslt  in  16  ALU result
- alu_rslt_hi  in  16  ALU high result
- alu_cc_out  in  8  ALU CC
- wr_we  out  1  one-cen writeback strobe
- wr_hi_we  out  1  high-word valid, with wr_we (div, lmul)
- wr_data  out  16  captured result
- wr_hi  out  16  captured high word
- wr_cc  out  8  captured CC

Behaviour:
- Reset: state IDLE; rdy=1; all other outputs 0. Reset mid-operation abandons the op; no wr_we is issued.
- States: IDLE, SETTLE, STEP, DIVW, DONE.
- IDLE: on req&rdy, latch op/a0/a1/cc_i into alu_* and the count from a1[7:0] (saturated to MAXSHIFT); rdy drops the same cen; go to SETTLE.
- SETTLE: wait SETTLE cen cycles, then dispatch on kind.
  - kind 0 or 3: capture alu_rslt, alu_rslt_hi (used only for kind 3), alu_cc_out; go to DONE.
  - kind 1, count 0: capture a0 and cc_i unchanged (ALU not stepped); go to DONE.
  - kind 1, count >0: go to STEP.
  - kind 2: pulse alu_div_en for one cen; go to DIVW.
- STEP: each cen, load alu_opnd0 from alu_rslt and alu_cc from alu_cc_out, then decrement count. When count reaches 0, capture; go to DONE. A shift by N therefore takes N+SETTLE cen cycles; C/V/N/Z are those of the final step.
- DIVW: ignore alu_busy on the pulse cen. Afterwards, wait until alu_busy=0, capture rslt (quotient) and rslt_hi (remainder); go to DONE.
- DONE: wr_we=1 for one cen; wr_hi_we=1 for kinds 2 and 3. Go to IDLE, rdy=1 the next cen. wr_data/wr_hi/wr_cc hold until the next capture.
- req while rdy=0 is ignored; there is no queue.
- cen low freezes everything, including the pulses.
- alu_op changes only on accept, so ALU decode is stable for the whole operation.

Decomposition:
- kind encodings (KIND_SINGLE, KIND_SHIFT, KIND_DIV, KIND_LMUL) go in jtkcpu.inc beside the opcode constants.
- No sub-module: single FSM plus a counter. Top-level tests wrap jtkcpu_aluctl + jtkcpu_alu together.

Test Plan:
- kind 0, op ADDA_IMM, a0=0x007F, a1=0x0001, cc_i=0 -> wr_data[7:0]=0x80; N=1, V=1, Z=0, C=0; wr_hi_we=0.
- kind 1, op ASLD_IMM, a0=0x1234, a1=0x0003 -> 3 STEP cycles; wr_data=0x91A0, C=0, N=1.
- kind 1, count 0, a0=0xBEEF, cc_i=0x05 -> wr_data=0xBEEF, wr_cc=0x05; alu_opnd0 never reloaded from alu_rslt.
- kind 2, op DIVXB, a0=0x0064, a1=0x0007 -> one alu_div_en pulse; wr_we after busy falls; wr_data=0x000E, wr_hi=0x0002, wr_hi_we=1.
- kind 3, op LMUL, a0=0x1234, a1=0x5678 -> wr_hi=0x0626, wr_data=0x0060, wr_hi_we=1.
- kind 1 shift by 10, assert rst after 4 steps -> outputs 0, rdy=1, no wr_we. Then req during a div (rdy=0) -> ignored, exactly one wr_we.
